// File: rtl/fifo_pkg.sv
// Shared types and constants for the write-side packet framer feeding the async FIFO.
package fifo_pkg;

  // LEN exists in every build so encodings stay stable; it is only reached
  // when FRAMER_LEN_FIELD_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    LEN,
    TRL
  } framer_state_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Payload counter must hold 0..max_len inclusive.
  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/fifo_pkt_framer.sv
// Frames a valid/ready byte stream as SOF, payload, [length], XOR checksum into the FIFO write port.
// Optional length byte before the checksum: define FRAMER_LEN_FIELD_EN.
module fifo_pkt_framer
  import fifo_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               MAX_LEN = 16,
  parameter logic [WIDTH-1:0] SOF     = WIDTH'(SOF_DEFAULT)
) (
  input  logic             clk_wr,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_en,
  input  logic             flag_full,
  output logic             pkt_done,
  output logic             trunc_err,
  output logic [15:0]      pkt_count
);

  localparam int            CW       = cnt_width(MAX_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LEN - 1);

  framer_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] csum_q;
  logic             at_limit;

  assign at_limit = (cnt_q == LAST_CNT);

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    case (state_q)
      IDLE: begin
        // The beat is only observed here; it is consumed in DATA after SOF.
        if (in_valid) state_d = HDR;
      end
      HDR: begin
        wr_data = SOF;
        wr_en   = !flag_full;
        if (!flag_full) state_d = DATA;
      end
      DATA: begin
        in_ready = !flag_full;
        wr_en    = in_valid && !flag_full;
        wr_data  = in_data;
        if (in_valid && !flag_full && (in_last || at_limit)) begin
`ifdef FRAMER_LEN_FIELD_EN
          state_d = LEN;
`else
          state_d = TRL;
`endif
        end
      end
`ifdef FRAMER_LEN_FIELD_EN
      LEN: begin
        wr_data = WIDTH'(cnt_q);
        wr_en   = !flag_full;
        if (!flag_full) state_d = TRL;
      end
`endif
      TRL: begin
        wr_data = csum_q;
        wr_en   = !flag_full;
        if (!flag_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      csum_q    <= '0;
      pkt_count <= '0;
      pkt_done  <= 1'b0;
      trunc_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_done  <= 1'b0;
      trunc_err <= 1'b0;
      case (state_q)
        HDR: begin
          if (!flag_full) begin
            cnt_q  <= '0;
            csum_q <= '0;
          end
        end
        DATA: begin
          if (in_valid && !flag_full) begin
            csum_q    <= csum_q ^ in_data;
            cnt_q     <= cnt_q + CW'(1);
            trunc_err <= at_limit && !in_last;
          end
        end
`ifdef FRAMER_LEN_FIELD_EN
        LEN: begin
          if (!flag_full) csum_q <= csum_q ^ WIDTH'(cnt_q);
        end
`endif
        TRL: begin
          if (!flag_full) begin
            pkt_done  <= 1'b1;
            pkt_count <= pkt_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Self-checking bench: a queue model of the expected FIFO byte stream, checked on every write.
module tb_fifo_pkt_framer;

  localparam int         MAX_LEN = 4;
  localparam logic [7:0] SOF_V   = 8'hA5;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0] d;
    bit         sof;
    bit         trl;
    bit         trunc;
  } exp_t;
  typedef exp_t exp_q_t[$];

  logic        clk_wr = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        flag_full;
  logic        pkt_done;
  logic        trunc_err;
  logic [15:0] pkt_count;

  int     n_checks = 0;
  int     n_errors = 0;
  exp_q_t exp_q;
  int     stall_left = 0;
  bit     rand_full = 1'b0;
  int     n_trunc_seen = 0;

  fifo_pkt_framer #(.WIDTH(8), .MAX_LEN(MAX_LEN), .SOF(SOF_V)) dut (
    .clk_wr    (clk_wr),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .flag_full (flag_full),
    .pkt_done  (pkt_done),
    .trunc_err (trunc_err),
    .pkt_count (pkt_count)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected FIFO stream for one upstream packet, straight from the framing rules.
  function automatic exp_q_t expand(input byte_q_t p);
    exp_q_t     r;
    int         i;
    int         n;
    logic [7:0] cs;
    exp_t       e;
    i = 0;
    while (i < p.size()) begin
      n  = (p.size() - i > MAX_LEN) ? MAX_LEN : p.size() - i;
      cs = 8'h00;
      e = '{d: SOF_V, sof: 1'b1, trl: 1'b0, trunc: 1'b0};
      r.push_back(e);
      for (int k = 0; k < n; k++) begin
        cs ^= p[i+k];
        e = '{d: p[i+k], sof: 1'b0, trl: 1'b0, trunc: (k == n - 1) && (i + n < p.size())};
        r.push_back(e);
      end
`ifdef FRAMER_LEN_FIELD_EN
      e = '{d: 8'(n), sof: 1'b0, trl: 1'b0, trunc: 1'b0};
      r.push_back(e);
      cs ^= 8'(n);
`endif
      e = '{d: cs, sof: 1'b0, trl: 1'b1, trunc: 1'b0};
      r.push_back(e);
      i += n;
    end
    return r;
  endfunction

  task automatic pin_model(input string name, input byte_q_t p, input byte_q_t want);
    exp_q_t r;
    r = expand(p);
    check({name, "_len"}, r.size(), want.size());
    for (int k = 0; k < r.size() && k < want.size(); k++)
      check({name, "_byte"}, r[k].d, want[k]);
  endtask

  // FIFO full generator: forced stall window, random, or never full.
  initial begin
    flag_full = 1'b0;
    forever begin
      @(posedge clk_wr);
      #1;
      if (stall_left > 0) begin
        flag_full = 1'b1;
        stall_left--;
      end else if (rand_full) begin
        flag_full = ($urandom_range(3) == 0);
      end else begin
        flag_full = 1'b0;
      end
    end
  end

  // Compare process: every write must be the next expected byte.
  int   cyc = 0;
  int   last_trl_cyc = -100;
  int   trl_written = 0;
  bit   exp_done = 1'b0;
  bit   exp_trunc = 1'b0;
  exp_t got_e;

  always @(negedge clk_wr) begin
    cyc++;
    if (rst_n !== 1'b1) begin
      exp_done     = 1'b0;
      exp_trunc    = 1'b0;
      trl_written  = 0;
      last_trl_cyc = -100;
    end else begin
      check("pkt_done", pkt_done, exp_done);
      check("trunc_err", trunc_err, exp_trunc);
      check("pkt_count", pkt_count, 16'(trl_written));
      if (trunc_err) n_trunc_seen++;
      exp_done  = 1'b0;
      exp_trunc = 1'b0;
      if (flag_full) begin
        check("wr_en_while_full", wr_en, 1'b0);
        check("in_ready_while_full", in_ready, 1'b0);
      end
      if (in_valid && in_ready) check("accepted_beat_written", wr_en, 1'b1);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", wr_data, 32'hFFFF_FFFF);
        end else begin
          got_e = exp_q.pop_front();
          check("wr_data", wr_data, got_e.d);
          if (got_e.sof) check("idle_gap_before_sof", (cyc - last_trl_cyc) >= 2, 1'b1);
          if (got_e.trl) begin
            exp_done = 1'b1;
            trl_written++;
            last_trl_cyc = cyc;
          end
          exp_trunc = got_e.trunc;
        end
      end
    end
  end

  task automatic drive_beat(input logic [7:0] d, input bit l);
    bit acc;
    int budget;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    acc      = 1'b0;
    budget   = 0;
    while (!acc && budget < 300) begin
      @(negedge clk_wr);
      acc = in_ready;
      @(posedge clk_wr);
      #1;
      budget++;
    end
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_packet(input byte_q_t p, input bit drop_valid);
    exp_q_t r;
    r = expand(p);
    foreach (r[k]) exp_q.push_back(r[k]);
    for (int k = 0; k < p.size(); k++) drive_beat(p[k], k == p.size() - 1);
    if (drop_valid) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(posedge clk_wr);
      #1;
      budget++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk_wr);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  byte_q_t p3, p6, p7f, want, pr;
  exp_t    ee;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    p3  = '{8'h11, 8'h22, 8'h33};
    p6  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    p7f = '{8'h7F};

    // Pin the model against hand-computed frames.
`ifdef FRAMER_LEN_FIELD_EN
    want = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h03, 8'h03};
    pin_model("model_p3", p3, want);
    want = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00, 8'hA5, 8'h05, 8'h06, 8'h02, 8'h01};
    pin_model("model_p6", p6, want);
    want = '{8'hA5, 8'h7F, 8'h01, 8'h7E};
    pin_model("model_p7f", p7f, want);
`else
    want = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h00};
    pin_model("model_p3", p3, want);
    want = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'hA5, 8'h05, 8'h06, 8'h03};
    pin_model("model_p6", p6, want);
    want = '{8'hA5, 8'h7F, 8'h7F};
    pin_model("model_p7f", p7f, want);
`endif

    repeat (3) @(posedge clk_wr);
    #1;
    check("reset_wr_en", wr_en, 1'b0);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_wr_data", wr_data, 8'h00);
    check("reset_pkt_count", pkt_count, 16'd0);
    rst_n = 1'b1;
    @(posedge clk_wr);
    #1;

    // Basic 3-beat packet, never full.
    send_packet(p3, 1'b1);
    wait_drain();
    check("count_after_p3", pkt_count, 16'd1);

    // Same packet with a 4-cycle stall inside DATA.
    fork
      send_packet(p3, 1'b1);
      begin : stall_arm
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
          @(negedge clk_wr);
          if (in_valid && in_ready) seen = 1'b1;
        end
        check("stall_armed", seen, 1'b1);
        stall_left = 4;
      end
    join
    wait_drain();
    check("count_after_stall", pkt_count, 16'd2);

    // Truncation at MAX_LEN, remainder framed as a new packet.
    send_packet(p6, 1'b1);
    wait_drain();
    check("count_after_trunc", pkt_count, 16'd4);
    check("trunc_pulses", n_trunc_seen, 1);

    // Back-to-back packets with in_valid held high throughout.
    send_packet(p3, 1'b0);
    send_packet(p7f, 1'b0);
    send_packet(p3, 1'b1);
    wait_drain();
    check("count_after_b2b", pkt_count, 16'd7);

    // Reset after two payload beats: framing abandoned, no trailer.
    ee = '{d: SOF_V, sof: 1'b1, trl: 1'b0, trunc: 1'b0};
    exp_q.push_back(ee);
    ee = '{d: 8'h10, sof: 1'b0, trl: 1'b0, trunc: 1'b0};
    exp_q.push_back(ee);
    ee = '{d: 8'h20, sof: 1'b0, trl: 1'b0, trunc: 1'b0};
    exp_q.push_back(ee);
    drive_beat(8'h10, 1'b0);
    drive_beat(8'h20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_wr_data", wr_data, 8'h00);
    check("midrst_pkt_count", pkt_count, 16'd0);
    check("midrst_pkt_done", pkt_done, 1'b0);
    check("midrst_trunc_err", trunc_err, 1'b0);
    check("midrst_partial_written", exp_q.size(), 0);
    in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk_wr);
    #3;
    rst_n = 1'b1;
    @(posedge clk_wr);
    #1;
    send_packet(p7f, 1'b1);
    wait_drain();
    check("count_after_reset_pkt", pkt_count, 16'd1);

    // Randomized packets, random back-pressure and idle gaps.
    rand_full = 1'b1;
    for (int n = 0; n < 40; n++) begin
      pr.delete();
      for (int k = 0; k < int'($urandom_range(10, 1)); k++) pr.push_back(8'($urandom));
      if ($urandom_range(1) == 0) begin
        send_packet(pr, 1'b1);
        repeat ($urandom_range(3)) @(posedge clk_wr);
        #1;
      end else begin
        send_packet(pr, 1'b0);
      end
    end
    in_valid  = 1'b0;
    rand_full = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
